// File: rtl/sequential_divider.sv
// Multi-cycle 4-bit restoring divider: quotient on ResL, remainder on ResH.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module sequential_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [3:0] ResL,
  output logic [3:0] ResH,
  output logic       DivZero,
  output logic       Overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef DIV_SIGNED_EN
  function automatic logic [3:0] neg4(input logic [3:0] v);
    return (~v) + 4'd1;
  endfunction

  // |-8| wraps to 4'b1000, which the unsigned datapath handles as 8
  function automatic logic [3:0] mag4(input logic [3:0] v);
    return v[3] ? neg4(v) : v;
  endfunction
`endif

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;
  logic       qneg_q, qneg_d;
  logic       rneg_q, rneg_d;
  logic       ovf_pend_q, ovf_pend_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] resl_q, resl_d;
  logic [3:0] resh_q, resh_d;
  logic       dz_q, dz_d;
  logic       ovf_q, ovf_d;

  logic [3:0] a_mag_s, b_mag_s;
  logic       a_neg_s, q_neg_s, ovf_s;
  logic [4:0] shift_s;
  logic       fits_s;
  logic [3:0] diff_s;

`ifdef DIV_SIGNED_EN
  assign a_mag_s = mag4(A);
  assign b_mag_s = mag4(B);
  assign a_neg_s = A[3];
  assign q_neg_s = A[3] ^ B[3];
  assign ovf_s   = (A == 4'h8) && (B == 4'hF);
`else
  assign a_mag_s = A;
  assign b_mag_s = B;
  assign a_neg_s = 1'b0;
  assign q_neg_s = 1'b0;
  assign ovf_s   = 1'b0;
`endif

  // Partial remainder stays below the divisor, so the 4-bit wrapped difference is exact
  assign shift_s = {rem_q, dvd_q[3]};
  assign fits_s  = (shift_s >= {1'b0, dvs_q});
  assign diff_s  = shift_s[3:0] - dvs_q;

  // Next-state, datapath and output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    ovf_pend_d = ovf_pend_q;
    resl_d     = resl_q;
    resh_d     = resh_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (B == 4'h0) begin
            state_d = S_DONE;
            resl_d  = 4'hF;
            resh_d  = A;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
          end else begin
            state_d    = S_CALC;
            cnt_d      = 2'd3;
            dvd_d      = a_mag_s;
            dvs_d      = b_mag_s;
            rem_d      = 4'h0;
            quo_d      = 4'h0;
            qneg_d     = q_neg_s;
            rneg_d     = a_neg_s;
            ovf_pend_d = ovf_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        dvd_d = {dvd_q[2:0], 1'b0};
        quo_d = {quo_q[2:0], fits_s};
        if (fits_s) begin
          rem_d = diff_s;
        end else begin
          rem_d = shift_s[3:0];
        end
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
`ifdef DIV_SIGNED_EN
        resl_d = qneg_q ? neg4(quo_q) : quo_q;
        resh_d = rneg_q ? neg4(rem_q) : rem_q;
        ovf_d  = ovf_pend_q;
`else
        resl_d = quo_q;
        resh_d = rem_q;
        ovf_d  = 1'b0;
`endif
        dz_d    = 1'b0;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      dvd_q      <= 4'h0;
      dvs_q      <= 4'h0;
      rem_q      <= 4'h0;
      quo_q      <= 4'h0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resl_q     <= 4'h0;
      resh_q     <= 4'h0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      resl_q     <= resl_d;
      resh_q     <= resh_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ResL     = resl_q;
  assign ResH     = resh_q;
  assign DivZero  = dz_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider; expectations follow the DIV_SIGNED_EN build.
module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_r, b_r;
  logic       busy, done, div_zero, overflow;
  logic [3:0] res_l, res_h;

  int checks   = 0;
  int failures = 0;

  sequential_divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (a_r),
    .B        (b_r),
    .busy     (busy),
    .done     (done),
    .ResL     (res_l),
    .ResH     (res_h),
    .DivZero  (div_zero),
    .Overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] el, input logic [3:0] eh,
                        input logic edz, input logic eov);
    check1({tag, "_idle_busy"}, busy, 1'b0);
    a_r   = a;
    b_r   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (b != 4'h0) begin
      for (int i = 0; i < 5; i++) begin
        check1({tag, "_busy"}, busy, 1'b1);
        check1({tag, "_early_done"}, done, 1'b0);
        tick();
      end
    end
    check1({tag, "_done"}, done, 1'b1);
    check1({tag, "_busy_at_done"}, busy, 1'b0);
    check4({tag, "_ResL"}, res_l, el);
    check4({tag, "_ResH"}, res_h, eh);
    check1({tag, "_DivZero"}, div_zero, edz);
    check1({tag, "_Overflow"}, overflow, eov);
    tick();
    check1({tag, "_done_pulse"}, done, 1'b0);
    check4({tag, "_ResL_hold"}, res_l, el);
  endtask

  logic [7:0] n_done;
  logic [7:0] idx0, idx1;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_r   = 4'h0;
    b_r   = 4'h0;
    tick();
    tick();
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check4("rst_ResL", res_l, 4'h0);
    check4("rst_ResH", res_h, 4'h0);
    check1("rst_DivZero", div_zero, 1'b0);
    check1("rst_Overflow", overflow, 1'b0);
    rst = 1'b0;
    tick();

    run_op("d7_2", 4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0);
`ifdef DIV_SIGNED_EN
    run_op("d9_2", 4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0);
    run_op("d7_E", 4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0);
    run_op("d9_E", 4'h9, 4'hE, 4'h3, 4'hF, 1'b0, 1'b0);
    run_op("d8_2", 4'h8, 4'h2, 4'hC, 4'h0, 1'b0, 1'b0);
    run_op("d8_F", 4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1);
    run_op("d6_3", 4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 1'b0);
    run_op("d5_0", 4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0);
    run_op("dE_3", 4'hE, 4'h3, 4'h0, 4'hE, 1'b0, 1'b0);
    run_op("dF_1", 4'hF, 4'h1, 4'hF, 4'h0, 1'b0, 1'b0);
`else
    run_op("d9_2", 4'h9, 4'h2, 4'h4, 4'h1, 1'b0, 1'b0);
    run_op("d7_E", 4'h7, 4'hE, 4'h0, 4'h7, 1'b0, 1'b0);
    run_op("d9_E", 4'h9, 4'hE, 4'h0, 4'h9, 1'b0, 1'b0);
    run_op("d8_2", 4'h8, 4'h2, 4'h4, 4'h0, 1'b0, 1'b0);
    run_op("d8_F", 4'h8, 4'hF, 4'h0, 4'h8, 1'b0, 1'b0);
    run_op("d6_3", 4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 1'b0);
    run_op("d5_0", 4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0);
    run_op("dE_3", 4'hE, 4'h3, 4'h4, 4'h2, 1'b0, 1'b0);
    run_op("dF_1", 4'hF, 4'h1, 4'hF, 4'h0, 1'b0, 1'b0);
`endif
    run_op("dF_F", 4'hF, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0);

    // start pulsed during CALC must be ignored
    a_r   = 4'h7;
    b_r   = 4'h2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a_r   = 4'hF;
    b_r   = 4'h1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check1("ign_busy", busy, 1'b1);
    check1("ign_done_early", done, 1'b0);
    tick();
    check1("ign_done", done, 1'b1);
    check4("ign_ResL", res_l, 4'h3);
    check4("ign_ResH", res_h, 4'h1);
    tick();
    check1("ign_done_pulse", done, 1'b0);
    check1("ign_idle", busy, 1'b0);

    // reset pulsed at edge 2 of a 7/2 operation
    a_r   = 4'h7;
    b_r   = 4'h2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check4("abort_ResL", res_l, 4'h0);
    check4("abort_ResH", res_h, 4'h0);
    check1("abort_DivZero", div_zero, 1'b0);
    tick();
    rst    = 1'b0;
    n_done = 8'd0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done) n_done = n_done + 8'd1;
    end
    check8("abort_no_done", n_done, 8'd0);
    check1("abort_idle_busy", busy, 1'b0);

    // start held high for 12 cycles: two operations, done pulses 6 cycles apart
    a_r    = 4'h7;
    b_r    = 4'h2;
    start  = 1'b1;
    n_done = 8'd0;
    idx0   = 8'hFF;
    idx1   = 8'hFF;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) begin
        if (n_done == 8'd0) idx0 = 8'(c);
        else idx1 = 8'(c);
        n_done = n_done + 8'd1;
      end
    end
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) n_done = n_done + 8'd1;
    end
    check8("hold_done_count", n_done, 8'd2);
    check8("hold_first_done", idx0, 8'd5);
    check8("hold_second_done", idx1, 8'd11);
    check4("hold_ResL", res_l, 4'h3);
    check1("hold_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Multi-cycle 4-bit divider: the inverse of the control unit's multiply path. It takes a dividend A and a divisor B, runs a restoring shift-subtract loop one quotient bit per clock, and returns the quotient on ResL and the remainder on ResH. The ResL/ResH/Overflow naming matches the control unit's result bus, so the divider can sit beside it as a fifth operation behind a start/done handshake.

## Interface
- No parameters; operand width fixed at 4 bits, matching the control unit.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- A  input  4  dividend; sampled on the accepting edge.
- B  input  4  divisor; sampled on the accepting edge.
- busy  output  1  high while a division is in progress (CALC, FIX).
- done  output  1  one-cycle pulse; results are valid from this cycle.
- ResL  output  4  quotient.
- ResH  output  4  remainder.
- DivZero  output  1  B was 0 for the completed operation.
- Overflow  output  1  quotient not representable (signed -8 / -1 only).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1, B≠0:
  - Latch |A| and |B| (magnitudes in 4 bits; |-8| = 4'b1000).
  - Latch the sign of A and the sign of A XOR the sign of B.
  - Set the bit counter to 3, clear the partial remainder, go to CALC.
- IDLE or DONE with start=1, B=0:
  - Go directly to DONE.
  - ResL=4'hF, ResH=A, DivZero=1, Overflow=0.
- CALC, each cycle:
  - Shift the next dividend bit (MSB first) into the 5-bit partial remainder.
  - Trial-subtract |B|. If non-negative, keep the difference and set quotient bit=1; otherwise restore and set quotient bit=0.
  - Counter decrements; after the counter-0 cycle, go to FIX.
- FIX:
  - Negate the quotient if the quotient sign is 1; negate the remainder if the dividend was negative.
  - Truncation is toward zero; the remainder takes the dividend's sign.
  - Register ResL/ResH/flags, go to DONE.
- Overflow: set when A=4'h8, B=4'hF. Result is ResL=4'h8, ResH=4'h0, via the normal path.
- DONE:
  - done=1 for one cycle.
  - Go to IDLE, or to CALC/DONE if a new start is accepted (back-to-back).
- start in CALC or FIX is ignored; no queueing.
- ResL, ResH, DivZero and Overflow hold their values until the next FIX or divide-by-zero DONE entry.

## Timing
- Reset values: state=IDLE, busy=0, done=0, ResL=0, ResH=0, DivZero=0, Overflow=0.
- Normal latency, with the accepting edge as edge 0:
  - busy=1 after edges 0 to 4 (4 CALC cycles, then FIX).
  - done=1 and results valid after edge 5.
  - Next start is accepted at edge 6 at the earliest (sampled during DONE).
- Divide-by-zero latency: done=1 after edge 0; busy stays 0.
- rst asserted mid-operation:
  - Aborts immediately; all outputs return to reset values.
  - No done is produced for the aborted operation.
- start held high continuously gives one operation per 6 cycles; done pulses never merge.

## Configuration
- DIV_SIGNED_EN defined:
  - A and B are two's complement.
  - Magnitude, sign fix-up and Overflow logic as above.
- DIV_SIGNED_EN undefined:
  - A and B are unsigned 0-15.
  - FIX performs no negation; Overflow is tied to 0.
  - Divide-by-zero gives ResL=4'hF, ResH=A.
  - Latency is unchanged (FIX still occupies one cycle).

## Test plan
- Signed build, A=7, B=2, start pulse -> done after edge 5; ResL=4'h3, ResH=4'h1, flags 0; busy high for exactly 5 cycles.
- Signed build, A=-7 (4'h9), B=2 -> ResL=4'hD (-3), ResH=4'hF (-1); then A=7, B=-2 -> ResL=4'hD, ResH=4'h1.
- Signed build, A=4'h8, B=4'hF -> ResL=4'h8, ResH=4'h0, Overflow=1; the next operation 6/3 clears Overflow and gives ResL=2, ResH=0.
- A=5, B=0 -> done after edge 0, busy never high; ResL=4'hF, ResH=4'h5, DivZero=1.
- Unsigned build, A=4'hE, B=4'h3 -> ResL=4'h4, ResH=4'h2; A=4'hF, B=4'h1 -> ResL=4'hF, Overflow=0.
- Reset and handshake robustness:
  - rst pulsed at edge 2 of a 7/2 operation -> outputs zero, no done.
  - start pulsed in CALC -> ignored.
  - start held high for 12 cycles -> exactly two done pulses, 6 cycles apart.
